// File: rtl/aibnd_rx_deser_if.sv
// Receive-side bus between the AIB IO-cell slice / adapter and the word builder.
// master drives the enable, alignment request and DDR samples; slave returns words and status.
interface aibnd_rx_deser_if #(
  parameter int unsigned WORD_W = 10
);
  logic              irx_en;
  logic              ialign_req;
  logic              rx_dat0;
  logic              rx_dat1;
  logic [WORD_W-1:0] orx_word;
  logic              orx_word_vld;
  logic              olocked;
  logic              oalign_ofs;
  logic              ohunt_fail;

  modport master (
    output irx_en, ialign_req, rx_dat0, rx_dat1,
    input  orx_word, orx_word_vld, olocked, oalign_ofs, ohunt_fail
  );

  modport slave (
    input  irx_en, ialign_req, rx_dat0, rx_dat1,
    output orx_word, orx_word_vld, olocked, oalign_ofs, ohunt_fail
  );
endinterface

// File: rtl/aibnd_rx_deser.sv
// AIB receive word builder: finds word alignment on a training marker in the
// two-bit-per-cycle DDR sample stream, then emits aligned WORD_W-bit words.
module aibnd_rx_deser #(
  parameter int unsigned       WORD_W     = 10,
  parameter logic [WORD_W-1:0] ALIGN_MARK = WORD_W'(10'h0FA),
  parameter int unsigned       LOCK_CNT   = 4,
  parameter int unsigned       HUNT_TO    = 64
) (
  input logic             istrbclk,
  input logic             irst,
  aibnd_rx_deser_if.slave rx
);

  localparam int unsigned HALF = WORD_W / 2;
  localparam int unsigned PH_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int unsigned TO_W = $clog2(HUNT_TO);

  localparam logic [PH_W-1:0] PH_LAST  = PH_W'(HALF - 1);
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(HUNT_TO - 1);
  localparam logic [3:0]      CNT_LOCK = 4'(LOCK_CNT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HUNT,
    S_VERIFY,
    S_LOCKED
  } state_t;

  state_t            state_q, state_d;
  logic [WORD_W-1:0] hist_q, hist_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic              ofs_q, ofs_d;
  logic              fail_q, fail_d;
  logic              vld_q, vld_d;
  logic [WORD_W-1:0] word_q, word_d;

  logic [WORD_W-1:0] win_a;
  logic [WORD_W-1:0] win_b;
  logic [WORD_W-1:0] win_sel;
  logic              hit_a;
  logic              hit_b;
  logic              hit_sel;
  logic              phase_wrap;
  logic              to_expired;

  // hist_q[WORD_W-1] is the newest bit; windows keep bit 0 as the earliest bit.
  assign win_a      = {rx.rx_dat1, rx.rx_dat0, hist_q[WORD_W-1:2]};
  assign win_b      = {rx.rx_dat0, hist_q[WORD_W-1:1]};
  assign win_sel    = ofs_q ? win_b : win_a;
  assign hit_a      = (win_a == ALIGN_MARK);
  assign hit_b      = (win_b == ALIGN_MARK);
  assign hit_sel    = (win_sel == ALIGN_MARK);
  assign phase_wrap = (phase_q == PH_LAST);
  assign to_expired = (to_q == TO_LAST);

  always_comb begin
    // NOTE: every next-state value gets a default before any branch, so no path leaves a latch.
    state_d = state_q;
    hist_d  = win_a;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    to_d    = to_q;
    ofs_d   = ofs_q;
    fail_d  = fail_q;
    vld_d   = 1'b0;
    word_d  = word_q;

    if (!rx.irx_en) begin
      state_d = S_IDLE;
      hist_d  = '0;
      phase_d = '0;
      cnt_d   = '0;
      to_d    = '0;
      ofs_d   = 1'b0;
      word_d  = '0;
    end else if (rx.ialign_req) begin
      state_d = S_HUNT;
      phase_d = '0;
      cnt_d   = '0;
      to_d    = '0;
      fail_d  = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: state_d = S_IDLE;

        S_HUNT: begin
          to_d = to_q + 1'b1;
          if (to_expired) begin
            state_d = S_IDLE;
            fail_d  = 1'b1;
            to_d    = '0;
          end else if (hit_a || hit_b) begin
            state_d = S_VERIFY;
            ofs_d   = !hit_a;
            phase_d = '0;
            cnt_d   = 4'd1;
          end
        end

        S_VERIFY: begin
          to_d    = to_q + 1'b1;
          phase_d = phase_wrap ? '0 : phase_q + 1'b1;
          if (to_expired) begin
            // The hunt budget beats a marker check landing in the same cycle.
            state_d = S_IDLE;
            fail_d  = 1'b1;
            to_d    = '0;
            cnt_d   = '0;
          end else if (phase_wrap) begin
            if (hit_sel) begin
              cnt_d = cnt_q + 1'b1;
              if (cnt_q + 4'd1 == CNT_LOCK) begin
                state_d = S_LOCKED;
                phase_d = '0;
                to_d    = '0;
              end
            end else begin
              state_d = S_HUNT;
              cnt_d   = '0;
            end
          end
        end

        S_LOCKED: begin
          phase_d = phase_wrap ? '0 : phase_q + 1'b1;
          if (phase_wrap) begin
            word_d = win_sel;
            vld_d  = 1'b1;
          end
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge istrbclk) begin
    if (irst) begin
      // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
      state_q <= S_IDLE;
      hist_q  <= '0;
      phase_q <= '0;
      cnt_q   <= '0;
      to_q    <= '0;
      ofs_q   <= 1'b0;
      fail_q  <= 1'b0;
      vld_q   <= 1'b0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
      ofs_q   <= ofs_d;
      fail_q  <= fail_d;
      vld_q   <= vld_d;
      word_q  <= word_d;
    end
  end

  assign rx.olocked      = (state_q == S_LOCKED);
  assign rx.oalign_ofs   = (state_q == S_LOCKED) & ofs_q;
  assign rx.orx_word     = word_q;
  assign rx.orx_word_vld = vld_q;
  assign rx.ohunt_fail   = fail_q;

endmodule

// File: tb/tb_aibnd_rx_deser.sv
// Bench for aibnd_rx_deser: table-driven lock scenarios, hand-written corner
// sequences, and a randomized run against a cycle-index based reference model.
module tb_aibnd_rx_deser;

  localparam int W        = 10;
  localparam int HALF     = W / 2;
  localparam int LOCK_CNT = 4;
  localparam int HUNT_TO  = 64;
  localparam logic [W-1:0] MARK = 10'h0FA;

  logic clk = 1'b0;
  logic rst;

  aibnd_rx_deser_if #(.WORD_W(W)) bus ();

  aibnd_rx_deser #(
    .WORD_W    (W),
    .ALIGN_MARK(MARK),
    .LOCK_CNT  (LOCK_CNT),
    .HUNT_TO   (HUNT_TO)
  ) dut (
    .istrbclk(clk),
    .irst    (rst),
    .rx      (bus.slave)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- bit source ----------------
  bit src[$];

  task automatic push_word(input logic [W-1:0] w);
    for (int i = 0; i < W; i++) src.push_back(w[i]);
  endtask

  // ---------------- reference model ----------------
  // Works on a queue of received bits and on cycle indices: checks happen at
  // fixed distances from the first match, words at fixed distances from lock.
  typedef enum {M_IDLE, M_HUNT, M_VERIFY, M_LOCKED} mmode_t;

  bit         model_on = 1'b0;
  mmode_t     m_mode   = M_IDLE;
  bit         m_hist[$];
  int         m_cyc    = 0;
  int         m_hunt0  = 0;
  int         m_t0     = 0;
  int         m_lock_t = 0;
  int         m_cnt    = 0;
  bit         m_ofs    = 1'b0;
  logic [W-1:0] e_word = '0;
  bit         e_vld    = 1'b0;
  bit         e_fail   = 1'b0;

  function automatic logic [W-1:0] last_w(input bit q[$]);
    logic [W-1:0] w;
    for (int i = 0; i < W; i++) w[i] = q[q.size() - W + i];
    return w;
  endfunction

  task automatic model_step(input bit r, input bit en, input bit req, input bit d0, input bit d1);
    bit s[$];
    logic [W-1:0] wa, wb, wsel;
    s = m_hist;
    s.push_back(d0);
    wb = last_w(s);
    s.push_back(d1);
    wa = last_w(s);
    wsel  = m_ofs ? wb : wa;
    e_vld = 1'b0;
    if (r || !en) begin
      m_mode = M_IDLE;
      m_hist.delete();
      repeat (W) m_hist.push_back(1'b0);
      e_word = '0;
      m_ofs  = 1'b0;
      if (r) e_fail = 1'b0;
    end else begin
      m_hist = s;
      void'(m_hist.pop_front());
      void'(m_hist.pop_front());
      if (req) begin
        m_mode  = M_HUNT;
        m_hunt0 = m_cyc + 1;
        e_fail  = 1'b0;
      end else begin
        case (m_mode)
          M_HUNT, M_VERIFY: begin
            if (m_cyc - m_hunt0 == HUNT_TO - 1) begin
              m_mode = M_IDLE;
              e_fail = 1'b1;
            end else if (m_mode == M_HUNT) begin
              if (wa == MARK || wb == MARK) begin
                m_mode = M_VERIFY;
                m_t0   = m_cyc;
                m_ofs  = (wa != MARK);
                m_cnt  = 1;
              end
            end else if ((m_cyc - m_t0) % HALF == 0) begin
              if (wsel == MARK) begin
                m_cnt++;
                if (m_cnt == LOCK_CNT) begin
                  m_mode   = M_LOCKED;
                  m_lock_t = m_cyc + 1;
                end
              end else begin
                m_mode = M_HUNT;
                m_cnt  = 0;
              end
            end
          end
          M_LOCKED: begin
            if ((m_cyc - m_lock_t) % HALF == HALF - 1) begin
              e_word = wsel;
              e_vld  = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
    m_cyc++;
  endtask

  // One clock cycle: drive, clock, sample 1 time unit after the edge.
  task automatic cyc(input bit r, input bit en, input bit req);
    bit d0, d1;
    bit e_lk;
    d0 = 1'b0;
    d1 = 1'b0;
    if (src.size() > 0) d0 = src.pop_front();
    if (src.size() > 0) d1 = src.pop_front();
    rst            = r;
    bus.irx_en     = en;
    bus.ialign_req = req;
    bus.rx_dat0    = d0;
    bus.rx_dat1    = d1;
    if (model_on) model_step(r, en, req, d0, d1);
    @(posedge clk);
    #1;
    if (model_on) begin
      e_lk = (m_mode == M_LOCKED);
      check("rand", {bus.orx_word, bus.orx_word_vld, bus.olocked, bus.oalign_ofs, bus.ohunt_fail},
                    {e_word, e_vld, e_lk, e_lk & m_ofs, e_fail});
    end
  endtask

  function automatic logic [31:0] all_out();
    return {18'd0, bus.orx_word, bus.orx_word_vld, bus.olocked, bus.oalign_ofs, bus.ohunt_fail};
  endfunction

  // ---------------- lock scenario table ----------------
  // Stream cycle k is the k-th cycle after the alignment request; expected
  // times are the cycle index in which the output is visible.
  typedef struct {
    int           delay;    // leading pad bits before the first marker
    int           corrupt;  // marker index to corrupt, -1 = none
    int           n_mark;
    logic [W-1:0] w0;
    logic [W-1:0] w1;
    int           lock_at;
    int           w0_at;
    int           w1_at;
    bit           ofs;
  } scen_t;

  task automatic run_scen(input int id, input scen_t s);
    int t;
    src.delete();
    cyc(1, 1, 0);
    cyc(1, 1, 0);
    cyc(0, 1, 1);
    repeat (s.delay) src.push_back(1'b0);
    for (int j = 0; j < s.n_mark; j++) push_word((j == s.corrupt) ? (MARK ^ 10'h001) : MARK);
    push_word(s.w0);
    push_word(s.w1);
    for (int k = 0; k <= s.w1_at + 1; k++) begin
      cyc(0, 1, 0);
      t = k + 1;
      check($sformatf("scen%0d_lock_vld@%0d", id, t), {bus.olocked, bus.orx_word_vld},
            {(t >= s.lock_at), (t == s.w0_at || t == s.w1_at)});
      if (t == s.lock_at) check($sformatf("scen%0d_ofs", id), bus.oalign_ofs, s.ofs);
      if (t == s.w0_at)   check($sformatf("scen%0d_w0", id), bus.orx_word, s.w0);
      if (t == s.w0_at + 2) check($sformatf("scen%0d_w0_hold", id), bus.orx_word, s.w0);
      if (t == s.w1_at)   check($sformatf("scen%0d_w1", id), bus.orx_word, s.w1);
    end
  endtask

  task automatic do_timeout(input string tag);
    src.delete();
    cyc(0, 1, 1);
    for (int k = 1; k <= HUNT_TO; k++) begin
      cyc(0, 1, 0);
      if (k >= HUNT_TO - 1) check($sformatf("%s_fail@%0d", tag, k + 1), bus.ohunt_fail, (k == HUNT_TO));
    end
    check({tag, "_unlocked"}, bus.olocked, 1'b0);
  endtask

  scen_t tbl[4];

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit lk;
    tbl[0] = '{delay: 0, corrupt: -1, n_mark: 4, w0: 10'h155, w1: 10'h2AA,
               lock_at: 20, w0_at: 25, w1_at: 30, ofs: 1'b0};
    tbl[1] = '{delay: 1, corrupt: -1, n_mark: 4, w0: 10'h155, w1: 10'h2AA,
               lock_at: 21, w0_at: 26, w1_at: 31, ofs: 1'b1};
    tbl[2] = '{delay: 0, corrupt: 2, n_mark: 7, w0: 10'h155, w1: 10'h2AA,
               lock_at: 35, w0_at: 40, w1_at: 45, ofs: 1'b0};
    tbl[3] = '{delay: 1, corrupt: 2, n_mark: 7, w0: 10'h3C5, w1: 10'h01F,
               lock_at: 36, w0_at: 41, w1_at: 46, ofs: 1'b1};

    rst = 1'b1;
    bus.irx_en = 1'b0;
    bus.ialign_req = 1'b0;
    bus.rx_dat0 = 1'b0;
    bus.rx_dat1 = 1'b0;

    // Reset with random inputs, then markers without a request must not lock.
    for (int i = 0; i < 3; i++) begin
      src.push_back(1'($urandom));
      src.push_back(1'($urandom));
      cyc(1, 1'($urandom), 1'($urandom));
      check($sformatf("reset_out%0d", i), all_out(), 32'd0);
    end
    src.delete();
    repeat (6) push_word(MARK);
    repeat (30) cyc(0, 1, 0);
    check("idle_no_lock", {bus.olocked, bus.orx_word_vld, bus.ohunt_fail}, 3'b000);

    // Table-driven lock scenarios.
    for (int i = 0; i < 4; i++) run_scen(i, tbl[i]);

    // Drop irx_en while locked, mid-word after a delivered word.
    run_scen(4, tbl[0]);
    cyc(0, 0, 0);
    check("dis_clear", {bus.olocked, bus.orx_word_vld, bus.orx_word}, 12'd0);

    // Timeout, hold through disable, clear by request.
    cyc(1, 1, 0);
    do_timeout("to1");
    cyc(0, 0, 0);
    check("to1_hold_dis", bus.ohunt_fail, 1'b1);
    src.delete();
    repeat (4) push_word(MARK);
    repeat (25) cyc(0, 1, 0);
    check("to1_idle_nolock", {bus.olocked, bus.ohunt_fail}, 2'b01);
    cyc(0, 1, 1);
    check("to1_req_clr", bus.ohunt_fail, 1'b0);

    // Timeout again, then irst clears the sticky flag.
    do_timeout("to2");
    cyc(1, 1, 0);
    check("to2_rst_clr", all_out(), 32'd0);

    // irst during VERIFY clears everything and parks in IDLE.
    cyc(0, 1, 1);
    src.delete();
    repeat (8) push_word(MARK);
    repeat (8) cyc(0, 1, 0);
    cyc(1, 1, 0);
    check("ver_rst_clr", all_out(), 32'd0);
    repeat (25) cyc(0, 1, 0);
    check("ver_rst_idle", bus.olocked, 1'b0);

    // Request while locked drops lock next cycle, then relocks.
    src.delete();
    cyc(1, 1, 0);
    cyc(0, 1, 1);
    repeat (14) push_word(MARK);
    repeat (22) cyc(0, 1, 0);
    check("relock_pre", bus.olocked, 1'b1);
    cyc(0, 1, 1);
    check("relock_drop", bus.olocked, 1'b0);
    lk = 1'b0;
    for (int k = 0; k < 30 && !lk; k++) begin
      cyc(0, 1, 0);
      lk = bus.olocked;
    end
    check("relock_again", lk, 1'b1);
    check("relock_ofs", bus.oalign_ofs, 1'b0);

    // Randomized run against the reference model.
    src.delete();
    model_on = 1'b1;
    cyc(1, 1, 0);
    for (int n = 0; n < 4000; n++) begin
      bit r, en, req;
      if (src.size() < 2) begin
        int unsigned p;
        p = $urandom_range(99);
        if (p < 75)      push_word(MARK);
        else if (p < 92) push_word(W'($urandom));
        else             src.push_back(1'($urandom));
      end
      if ($urandom_range(199) == 0) src[0] = ~src[0];
      r   = ($urandom_range(499) == 0);
      en  = ($urandom_range(149) != 0);
      req = (m_mode == M_IDLE) ? ($urandom_range(7) == 0) : ($urandom_range(249) == 0);
      cyc(r, en, req);
    end
    model_on = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aibnd_rx_deser.md
Name: aibnd_rx_deser

Overview:
- Receive-side word builder directly downstream of the AIB IO-cell digital slice.
- Consumes the two per-cycle receive sample bits (first/second DDR half) in the strobe clock domain and finds word alignment with a training marker.
- Once aligned, delivers parallel WORD_W-bit words with a valid strobe to the adapter.

Parameters:
- WORD_W, 10, deserialised word width; even, 4..32.
- ALIGN_MARK, 10'h0FA, training marker, WORD_W bits, bit 0 received first.
- LOCK_CNT, 4, consecutive marker matches at a fixed offset and phase required for lock; 2..15.
- HUNT_TO, 64, cycles allowed in HUNT+VERIFY before failure; 8..4095.

Ports:
- istrbclk  in  1  receive strobe clock; all logic rises on it.
- irst  in  1  synchronous reset, active-high.
- irx_en  in  1  receive path enable.
- ialign_req  in  1  level; start or restart alignment.
- rx_dat0  in  1  first-half sample of the cycle (earlier bit).
- rx_dat1  in  1  second-half sample of the cycle (later bit).
- orx_word  out  WORD_W  aligned word; bit 0 = earliest bit.
- orx_word_vld  out  1  one-cycle strobe, orx_word valid.
- olocked  out  1  alignment locked.
- oalign_ofs  out  1  locked bit offset (0 = word ends on rx_dat1, 1 = word ends on rx_dat0).
- ohunt_fail  out  1  sticky alignment timeout.

Behaviour:
- Bit stream order per cycle: rx_dat0, then rx_dat1.
- A registered history of the last WORD_W bits is combined with the current inputs to form two candidate windows:
  - Window A (offset 0): the last WORD_W bits ending with the current rx_dat1.
  - Window B (offset 1): the last WORD_W bits ending with the current rx_dat0.
- States:
  - IDLE (reset state).
  - HUNT.
  - VERIFY: phase counter 0..WORD_W/2-1, match counter, captured offset.
  - LOCKED.
- Priority each cycle: irst > !irx_en > ialign_req > normal transitions.
- irst or !irx_en:
  - Next state IDLE.
  - History, phase, match and timeout counters cleared.
  - olocked=0, orx_word_vld=0, orx_word=0, oalign_ofs=0.
  - ohunt_fail is cleared by irst only; !irx_en holds it.
- ialign_req=1 with irx_en=1, in any state:
  - Next state HUNT.
  - Counters cleared, olocked=0, ohunt_fail cleared.
- HUNT: a match means window A or B equals ALIGN_MARK; A wins if both match.
  - On a match: capture the offset, set phase=0 and match count=1, go to VERIFY.
- VERIFY: phase increments every cycle and wraps at WORD_W/2-1 → 0.
  - At each wrap, check the captured-offset window.
  - Match: count+1; when count reaches LOCK_CNT, go to LOCKED with phase 0.
  - Mismatch: return to HUNT with count 0. Match and timeout in the same cycle: timeout wins.
- Timeout: a counter runs in HUNT and VERIFY.
  - When it reaches HUNT_TO-1 without entering LOCKED, go to IDLE and set ohunt_fail=1.
  - ohunt_fail holds until the next ialign_req or irst.
- LOCKED: olocked=1, oalign_ofs = captured offset.
  - Phase keeps counting modulo WORD_W/2.
  - On each wrap, the selected window is registered to orx_word and orx_word_vld pulses for 1 cycle.
  - Latency: word visible the cycle after its last bit is presented.
  - orx_word holds between strobes.
  - No loss detection; data content is not checked after lock.
- The history shift register advances every cycle with irx_en=1, including IDLE.
- Timing for WORD_W=10, LOCK_CNT=4:
  - First match in cycle t0 gives checks at t0+5, t0+10 and t0+15.
  - olocked goes high in t0+16.
  - The first data word is complete at t0+20; orx_word_vld pulses in t0+21, then every 5 cycles.

Test Plan:
- Reset: irst=1 for 3 cycles with random inputs → all outputs 0; state IDLE, so no lock without ialign_req.
- Offset-0 lock:
  - ialign_req pulse, then a repeated 10'h0FA stream, LSB first, with the marker ending on rx_dat1 in cycle t0.
  - Then data words 10'h155 and 10'h2AA.
  - Expect olocked=1 at t0+16, oalign_ofs=0, orx_word=10'h155 with vld at t0+21, 10'h2AA at t0+26.
- Offset-1 lock: same stream delayed by one bit → oalign_ofs=1, same cycle timing, identical words.
- Verify failure: corrupt the 3rd marker (t0+10) → return to HUNT, olocked stays 0. The next clean marker run locks 16 cycles after its first match.
- Timeout: ialign_req, then an all-zero stream for 64 cycles → ohunt_fail=1 in the cycle after the 64th, state IDLE. A new ialign_req clears it the next cycle.
- Disable/restart:
  - Drop irx_en while LOCKED mid-word → next cycle olocked=0, orx_word_vld=0, orx_word=0.
  - Assert irst during VERIFY → all cleared, including ohunt_fail.
  - ialign_req while LOCKED → olocked=0 next cycle, relock proceeds.
